// File: rtl/adder_arb_pkg.sv
// Shared types and width helpers for the adder stream arbiter.
// Latency: none, declarations only.
// Backpressure: not applicable.
package adder_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } arb_state_t;

    // Requester ID width; a single requester still gets a 1-bit ID.
    function automatic int id_width(input int num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

    // Skid payload layout: {tdata, tkeep, tlast, tid, constant}.
    function automatic int skid_payload_width(input int data_w, input int const_w, input int id_w);
        return data_w + data_w / 8 + 1 + id_w + const_w;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid stage between the arbiter mux and the adder.
// Latency: a pushed word is visible on dn_vld one cycle later.
// Backpressure: up_rdy is a register view (skid slot empty); one extra word absorbed after dn stalls.
module axis_skid_buffer #(
    parameter int C_PAYLOAD_WIDTH = 8
) (
    input  logic                       s_axis_aclk,
    input  logic                       s_axis_areset,
    input  logic                       up_vld,
    output logic                       up_rdy,
    input  logic [C_PAYLOAD_WIDTH-1:0] up_dat,
    output logic                       dn_vld,
    input  logic                       dn_rdy,
    output logic [C_PAYLOAD_WIDTH-1:0] dn_dat,
    output logic                       occupied
);

    logic                       head_vld;
    logic [C_PAYLOAD_WIDTH-1:0] head_dat;
    logic                       skid_vld;
    logic [C_PAYLOAD_WIDTH-1:0] skid_dat;
    logic                       push;
    logic                       head_free;

    assign up_rdy    = !skid_vld;
    assign push      = up_vld && up_rdy;
    assign head_free = !head_vld || dn_rdy;
    assign dn_vld    = head_vld;
    assign dn_dat    = head_dat;
    assign occupied  = head_vld || skid_vld;

    // Head feeds the output; the skid slot only fills when the head is stalled.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            head_vld <= 1'b0;
            head_dat <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (head_free) begin
            if (skid_vld) begin
                head_vld <= 1'b1;
                head_dat <= skid_dat;
                skid_vld <= 1'b0;
            end else begin
                head_vld <= push;
                if (push) begin
                    head_dat <= up_dat;
                end
            end
        end else if (push) begin
            skid_vld <= 1'b1;
            skid_dat <= up_dat;
        end
    end

endmodule

// File: rtl/adder_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one shared constant-adder stream.
// Latency: accepted beat on m_axis one cycle later; one idle arbitration cycle between packets.
// Backpressure: tready comes from registers only; skid absorbs one beat, then the grantee stalls.
module adder_stream_arbiter
    import adder_arb_pkg::*;
#(
    parameter int   C_NUM_REQ          = 4,
    parameter int   C_AXIS_TDATA_WIDTH = 512,
    parameter int   C_ADDER_BIT_WIDTH  = 32,
    localparam int  C_ID_WIDTH         = id_width(C_NUM_REQ)
) (
    input  logic                                      s_axis_aclk,
    input  logic                                      s_axis_areset,
    input  logic [C_NUM_REQ*C_ADDER_BIT_WIDTH-1:0]    ctrl_constants,
    input  logic [C_NUM_REQ-1:0]                      s_axis_tvalid,
    output logic [C_NUM_REQ-1:0]                      s_axis_tready,
    input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [C_NUM_REQ-1:0]                      s_axis_tlast,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]             m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic                                      m_axis_tlast,
    output logic [C_ID_WIDTH-1:0]                     m_axis_tid,
    output logic [C_ADDER_BIT_WIDTH-1:0]              m_axis_constant,
    output logic                                      busy
);

    localparam int KEEP_W = C_AXIS_TDATA_WIDTH / 8;
    localparam int PAY_W  = skid_payload_width(C_AXIS_TDATA_WIDTH, C_ADDER_BIT_WIDTH, C_ID_WIDTH);
    localparam logic [C_ID_WIDTH-1:0] LAST_ID = C_ID_WIDTH'(C_NUM_REQ - 1);

    arb_state_t                    state;
    logic [C_ID_WIDTH-1:0]         grant_id;
    logic [C_ID_WIDTH-1:0]         rr_ptr;
    logic [C_ADDER_BIT_WIDTH-1:0]  const_r;

    logic [C_AXIS_TDATA_WIDTH-1:0] req_tdata [C_NUM_REQ];
    logic [KEEP_W-1:0]             req_tkeep [C_NUM_REQ];
    logic [C_ADDER_BIT_WIDTH-1:0]  req_const [C_NUM_REQ];

    logic [C_ID_WIDTH-1:0]         pick;
    logic [C_ID_WIDTH-1:0]         cand;
    logic                          found;
    logic                          skid_up_rdy;
    logic                          accept;
    logic                          sel_tlast;
    logic [PAY_W-1:0]              skid_up_dat;
    logic [PAY_W-1:0]              skid_dn_dat;
    logic                          skid_occupied;

    for (genvar g = 0; g < C_NUM_REQ; g++) begin : g_split
        assign req_tdata[g] = s_axis_tdata[g*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
        assign req_tkeep[g] = s_axis_tkeep[g*KEEP_W +: KEEP_W];
        assign req_const[g] = ctrl_constants[g*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH];
    end

    // First valid requester starting at rr_ptr, wrapping past the last ID.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        cand  = rr_ptr;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (!found && s_axis_tvalid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
        end
    end

    // Only the grantee sees ready, and only while the skid slot is free.
    always_comb begin
        s_axis_tready = '0;
        if (state == ST_PKT) begin
            s_axis_tready[grant_id] = skid_up_rdy;
        end
    end

    assign accept      = s_axis_tvalid[grant_id] && s_axis_tready[grant_id];
    assign sel_tlast   = s_axis_tlast[grant_id];
    assign skid_up_dat = {req_tdata[grant_id], req_tkeep[grant_id], sel_tlast, grant_id, const_r};

    // Grant FSM: arbitrate in IDLE, hold the grant until the tlast beat is accepted.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            const_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant_id <= pick;
                        const_r  <= req_const[pick];
                        state    <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (accept && sel_tlast) begin
                        state  <= ST_IDLE;
                        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axis_skid_buffer #(
        .C_PAYLOAD_WIDTH(PAY_W)
    ) u_skid (
        .s_axis_aclk  (s_axis_aclk),
        .s_axis_areset(s_axis_areset),
        .up_vld       (accept),
        .up_rdy       (skid_up_rdy),
        .up_dat       (skid_up_dat),
        .dn_vld       (m_axis_tvalid),
        .dn_rdy       (m_axis_tready),
        .dn_dat       (skid_dn_dat),
        .occupied     (skid_occupied)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_constant} = skid_dn_dat;
    assign busy = (state == ST_PKT) || skid_occupied;

endmodule
